// File: rtl/timer_irq.sv
// Countdown timer raising a maskable interrupt toward the CP0 HWInt bit; optional TIMER_PRESCALE_EN adds CTRL[7:4] prescaler.
// Latency: EN written at E0 loads COUNT at E2, IRQ rises at E(N+2) (E(2+N*2^PS) with prescaler); reads are combinational.
// Backpressure: none, a bus access is accepted every cycle; IRQ is level, sticky in one-shot until a CTRL write.
module timer_irq #(
  parameter logic [31:0] RESET_PRESET = 32'd0,
  parameter int          CTRL_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  A,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

`ifdef TIMER_PRESCALE_EN
  localparam int CW = (CTRL_W > 8) ? CTRL_W : 8;
`else
  localparam int CW = CTRL_W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ctrl_q;
  logic [31:0]     preset_q;
  logic [31:0]     count_q, count_d;
  logic            irq_flag;
  logic            flag_set, flag_clr, en_clr;
  logic            ctrl_wr, preset_wr;
  logic            en, auto_rld, tick;

  assign ctrl_wr   = WE && (A == 2'd0);
  assign preset_wr = WE && (A == 2'd1);
  assign en        = ctrl_q[0];
  // MODE 1x falls back to one-shot, so only 01 reloads
  assign auto_rld  = (ctrl_q[2:1] == 2'b01);

`ifdef TIMER_PRESCALE_EN
  logic [15:0] psc_q;
  logic [15:0] psc_lim;
  logic [3:0]  ps;

  assign ps      = ctrl_q[7:4];
  assign psc_lim = (16'd1 << ps) - 16'd1;
  assign tick    = (psc_q == psc_lim);

  // Prescaler only runs while actively counting; LOAD/IDLE restart the divide period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q <= 16'd0;
    end else if (state_q == S_CNT && en) begin
      psc_q <= tick ? 16'd0 : psc_q + 16'd1;
    end else if (state_q == S_LOAD || state_q == S_IDLE) begin
      psc_q <= 16'd0;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Next-state and datapath decisions; FSM acts on registered CTRL
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    flag_set = 1'b0;
    flag_clr = 1'b0;
    en_clr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        // A zero preset is already expired, keeping the N+2 edge latency for N=0
        if (preset_q == 32'd0) begin
          flag_set = 1'b1;
          state_d  = S_INT;
        end else begin
          state_d  = S_CNT;
        end
      end
      S_CNT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d  = 32'd0;
            flag_set = 1'b1;
            state_d  = S_INT;
          end
        end
      end
      S_INT: begin
        if (auto_rld) begin
          flag_clr = 1'b1;
          state_d  = S_LOAD;
        end else begin
          en_clr   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and COUNT registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // CTRL and PRESET; a bus write to CTRL overrides the one-shot EN clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      preset_q <= RESET_PRESET;
    end else begin
      if (ctrl_wr)     ctrl_q    <= Din[CW-1:0];
      else if (en_clr) ctrl_q[0] <= 1'b0;
      if (preset_wr)   preset_q  <= Din;
    end
  end

  // Interrupt flag: expiry set beats any clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_flag <= 1'b0;
    end else if (flag_set) begin
      irq_flag <= 1'b1;
    end else if (ctrl_wr || flag_clr) begin
      irq_flag <= 1'b0;
    end
  end

  // Combinational register read mux
  always_comb begin
    Dout = 32'd0;
    case (A)
      2'd0:    Dout = {{(32-CW){1'b0}}, ctrl_q};
      2'd1:    Dout = preset_q;
      2'd2:    Dout = count_q;
      default: Dout = 32'd0;
    endcase
  end

  assign IRQ = irq_flag & ctrl_q[3];

endmodule
